fnd_scan_driver: RTL

Consumer end of the 1 kHz scan clock: takes the divided clock produced by the system clock divider, plus a 14-bit binary count, and drives a 4-digit common-anode FND. The divided clock is synchronized and edge-detected in the 100 MHz domain. Once per frame, the block converts the latched value to BCD with a sequential double-dabble. Each divided-clock period it strobes one digit with its segment font.

---
 rtl/fnd_scan_driver_if.sv | 11 +
 rtl/fnd_scan_driver.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fnd_scan_driver_if.sv
// Display-side bundle for fnd_scan_driver: scan clock and value in, digit strobes out.
interface fnd_scan_driver_if;
    logic        i_scan_clk;
    logic [13:0] i_value;
    logic [3:0]  o_fnd_com;
    logic [7:0]  o_fnd_font;
    logic        o_frame_done;

    modport master (output i_scan_clk, i_value, input o_fnd_com, o_fnd_font, o_frame_done);
    modport slave  (input i_scan_clk, i_value, output o_fnd_com, o_fnd_font, o_frame_done);
endinterface

// File: rtl/fnd_scan_driver.sv
// 4-digit common-anode FND scanner with per-frame sequential double-dabble conversion.
// Optional macro FND_LZ_BLANK_EN blanks leading-zero digits (ones digit always shown).
//
// state     | meaning
// ST_IDLE   | waiting for a wrap tick to capture a new value
// ST_SHIFT  | 14 add-3/shift iterations, one per cycle
// ST_COMMIT | copy BCD digits to display registers, pulse frame_done
module fnd_scan_driver #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_VALUE   = 9999
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    fnd_scan_driver_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

    localparam logic [13:0] MAX_V = 14'(MAX_VALUE);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   scan_prev_q, scan_prev_d;
    logic [1:0]             idx_q, idx_d;
    logic                   started_q, started_d;
    state_t                 state_q, state_d;
    logic [3:0]             iter_q, iter_d;
    logic [29:0]            shreg_q, shreg_d;
    logic [15:0]            bcd_q, bcd_d;
    logic [3:0]             com_q, com_d;
    logic [7:0]             font_q, font_d;
    logic                   done_q, done_d;

    logic        tick, wrap, blank;
    logic [29:0] dd_adj;
    logic [3:0]  digit;

    function automatic logic [7:0] seg_font(input logic [3:0] d);
        case (d)
            4'd0:    seg_font = 8'hC0;
            4'd1:    seg_font = 8'hF9;
            4'd2:    seg_font = 8'hA4;
            4'd3:    seg_font = 8'hB0;
            4'd4:    seg_font = 8'h99;
            4'd5:    seg_font = 8'h92;
            4'd6:    seg_font = 8'h82;
            4'd7:    seg_font = 8'hF8;
            4'd8:    seg_font = 8'h80;
            4'd9:    seg_font = 8'h90;
            default: seg_font = 8'hFF;
        endcase
    endfunction

    assign tick = sync_q[SYNC_STAGES-1] & ~scan_prev_q;
    assign wrap = tick & (idx_q == 2'd3);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync_q      <= '0;
            scan_prev_q <= 1'b0;
            idx_q       <= 2'd3;
            started_q   <= 1'b0;
            state_q     <= ST_IDLE;
            iter_q      <= 4'd0;
            shreg_q     <= '0;
            bcd_q       <= '0;
            com_q       <= 4'b1111;
            font_q      <= 8'hFF;
            done_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            scan_prev_q <= scan_prev_d;
            idx_q       <= idx_d;
            started_q   <= started_d;
            state_q     <= state_d;
            iter_q      <= iter_d;
            shreg_q     <= shreg_d;
            bcd_q       <= bcd_d;
            com_q       <= com_d;
            font_q      <= font_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], bus.i_scan_clk};
        scan_prev_d = sync_q[SYNC_STAGES-1];
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        started_d   = started_q | tick;
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        dd_adj  = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (wrap) begin
                    shreg_d = {16'd0, (bus.i_value > MAX_V) ? MAX_V : bus.i_value};
                    iter_d  = 4'd13;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                for (int n = 0; n < 4; n++) begin
                    if (dd_adj[14+4*n +: 4] >= 4'd5)
                        dd_adj[14+4*n +: 4] = dd_adj[14+4*n +: 4] + 4'd3;
                end
                shreg_d = {dd_adj[28:0], 1'b0};
                if (iter_q == 4'd0) state_d = ST_COMMIT;
                else                iter_d  = iter_q - 4'd1;
            end
            ST_COMMIT: begin
                bcd_d   = shreg_q[29:14];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (idx_q)
            2'd0:    digit = bcd_q[3:0];
            2'd1:    digit = bcd_q[7:4];
            2'd2:    digit = bcd_q[11:8];
            default: digit = bcd_q[15:12];
        endcase
`ifdef FND_LZ_BLANK_EN
        case (idx_q)
            2'd3:    blank = (bcd_q[15:12] == 4'd0);
            2'd2:    blank = (bcd_q[15:8]  == 8'd0);
            2'd1:    blank = (bcd_q[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        com_d  = started_q ? ~(4'b0001 << idx_q) : 4'b1111;
        font_d = (started_q && !blank) ? seg_font(digit) : 8'hFF;
    end

    assign bus.o_fnd_com    = com_q;
    assign bus.o_fnd_font   = font_q;
    assign bus.o_frame_done = done_q;
endmodule
